// File: rtl/census_cost_aggregator_pkg.sv
// Shared width and latency helpers for the census cost aggregator (package cca_pkg).
package cca_pkg;

    localparam int CCA_STAGE_LAT = 2;

    function automatic int ncb_f(input int wc);
        return wc * wc - 1;
    endfunction

    function automatic int nbc_f(input int ncb);
        return $clog2(ncb + 1);
    endfunction

    function automatic int csw_f(input int ncb, input int wh);
        return $clog2(ncb * wh + 1);
    endfunction

    function automatic int nobit_f(input int ncb, input int wh);
        return $clog2(ncb * wh * wh + 1);
    endfunction

    function automatic int lpc_f(input int ncb);
        return $clog2(ncb);
    endfunction

    function automatic int lat_f(input int ncb);
        return lpc_f(ncb) + CCA_STAGE_LAT;
    endfunction

endpackage

// File: rtl/census_cost_aggregator_if.sv
// Pixel-in / window-cost-out bus of the census cost aggregator.
interface census_cost_aggregator_if
    import cca_pkg::*;
#(
    parameter int NCB   = ncb_f(7),
    parameter int NOBIT = nobit_f(ncb_f(7), 13)
);
    logic [NCB-1:0]   i_data_l;
    logic [NCB-1:0]   i_data_r;
    logic             i_dval;
    logic             i_sof;
    logic             o_dval;
    logic             o_sof;
    logic [NOBIT-1:0] o_data;

    modport master (
        output i_data_l, i_data_r, i_dval, i_sof,
        input  o_dval, o_sof, o_data
    );

    modport slave (
        input  i_data_l, i_data_r, i_dval, i_sof,
        output o_dval, o_sof, o_data
    );
endinterface

// File: rtl/census_cost_aggregator_popcount_pipe.sv
// Registered binary adder-tree popcount with a valid/tag pipe aligned to its latency of $clog2(W).
module popcount_pipe
    import cca_pkg::*;
#(
    parameter int W  = 48,
    parameter int TW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_dval,
    input  logic [TW-1:0]         i_tag,
    input  logic [W-1:0]          i_data,
    output logic                  o_dval,
    output logic [TW-1:0]         o_tag,
    output logic [nbc_f(W)-1:0]   o_data
);
    localparam int NBC = nbc_f(W);
    localparam int LPC = lpc_f(W);
    localparam int NP  = 1 << LPC;

    logic [NP-1:0]             bits_s;
    logic [NP-1:1][NBC-1:0]    node_r;
    logic [LPC-1:0]            vld_r;
    logic [LPC-1:0][TW-1:0]    tag_r;

    assign bits_s = NP'(i_data);

    // heap-ordered tree: node k adds children 2k and 2k+1, the deepest level adds input bit pairs
    always_ff @(posedge i_clk) begin
        for (int k = NP / 2; k < NP; k++) begin
            node_r[k] <= NBC'(bits_s[2*k-NP]) + NBC'(bits_s[2*k-NP+1]);
        end
        for (int k = 1; k < NP / 2; k++) begin
            node_r[k] <= node_r[2*k] + node_r[2*k+1];
        end
    end

    // valid and sideband tag travel alongside the tree levels
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_r <= {LPC{1'b0}};
            tag_r <= {(LPC*TW){1'b0}};
        end else begin
            vld_r[0] <= i_dval;
            tag_r[0] <= i_tag;
            for (int i = 1; i < LPC; i++) begin
                vld_r[i] <= vld_r[i-1];
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign o_dval = vld_r[LPC-1];
    assign o_tag  = tag_r[LPC-1];
    assign o_data = node_r[1];

endmodule

// File: rtl/census_cost_aggregator.sv
// Census Hamming cost summed over a WH x WH box with column/row sliding sums, latency LPC+2.
// Define CCA_BORDER_MASK_EN to emit only complete windows (o_data forced to 0 otherwise).
module census_cost_aggregator
    import cca_pkg::*;
#(
    parameter int WC = 7,
    parameter int WH = 13,
    parameter int M  = 650
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    census_cost_aggregator_if.slave  bus
);
    localparam int NCB   = ncb_f(WC);
    localparam int NBC   = nbc_f(NCB);
    localparam int CSW   = csw_f(NCB, WH);
    localparam int NOBIT = nobit_f(NCB, WH);
    localparam int XW    = $clog2(M);
    localparam int YW    = $clog2(WH + 1);
    localparam int RW    = $clog2(WH);

    logic             pc_dval_s;
    logic [0:0]       pc_tag_s;
    logic [NBC-1:0]   pc_cost_s;

    logic [XW-1:0]    x_r, px_s, x1_r;
    logic [YW-1:0]    y_r, py_s;
    logic [RW-1:0]    rp_r, prp_s;
    logic [CSW-1:0]   cs_mem [0:M-1];
    logic [NBC-1:0]   hist_mem [0:WH-1][0:M-1];
    logic [CSW-1:0]   cs_old_s, cs_sub_s, cs_new_s, col_r;
    logic             win_s, win1_r, d1_r, s1_r;

    logic [WH-1:0][CSW-1:0] sr_r;
    logic [NOBIT-1:0] s_r, s_base_s, s_sub_s, s_next_s, o_data_r;
    logic             o_dval_r, o_sof_r;

    popcount_pipe #(.W(NCB), .TW(1)) u_popcount (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_dval (bus.i_dval),
        .i_tag  (bus.i_sof & bus.i_dval),
        .i_data (bus.i_data_l ^ bus.i_data_r),
        .o_dval (pc_dval_s),
        .o_tag  (pc_tag_s),
        .o_data (pc_cost_s)
    );

    // column stage: pixel position (sof restarts at origin) and updated column sum
    always_comb begin
        px_s  = x_r;
        py_s  = y_r;
        prp_s = rp_r;
        if (pc_tag_s[0]) begin
            px_s  = {XW{1'b0}};
            py_s  = {YW{1'b0}};
            prp_s = {RW{1'b0}};
        end else begin
            px_s  = x_r;
            py_s  = y_r;
            prp_s = rp_r;
        end
        // y gating makes stale RAM contents harmless after reset or a frame restart
        if (py_s == {YW{1'b0}}) cs_old_s = {CSW{1'b0}};
        else                    cs_old_s = cs_mem[px_s];
        if (py_s < YW'(WH))     cs_sub_s = {CSW{1'b0}};
        else                    cs_sub_s = CSW'(hist_mem[prp_s][px_s]);
        cs_new_s = cs_old_s + CSW'(pc_cost_s) - cs_sub_s;
`ifdef CCA_BORDER_MASK_EN
        win_s = (px_s >= XW'(WH - 1)) && (py_s >= YW'(WH - 1));
`else
        win_s = 1'b1;
`endif
    end

    // position counters: x wraps per line, y saturates at WH, rp names the oldest history row
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x_r  <= {XW{1'b0}};
            y_r  <= {YW{1'b0}};
            rp_r <= {RW{1'b0}};
        end else if (pc_dval_s) begin
            if (px_s == XW'(M - 1)) begin
                x_r  <= {XW{1'b0}};
                y_r  <= (py_s == YW'(WH)) ? py_s : py_s + YW'(1);
                rp_r <= (prp_s == RW'(WH - 1)) ? {RW{1'b0}} : prp_s + RW'(1);
            end else begin
                x_r  <= px_s + XW'(1);
                y_r  <= py_s;
                rp_r <= prp_s;
            end
        end
    end

    // column-sum and cost-history RAM writes
    always_ff @(posedge i_clk) begin
        if (pc_dval_s) begin
            cs_mem[px_s]          <= cs_new_s;
            hist_mem[prp_s][px_s] <= pc_cost_s;
        end
    end

    // column stage pipeline register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            d1_r   <= 1'b0;
            s1_r   <= 1'b0;
            win1_r <= 1'b0;
            x1_r   <= {XW{1'b0}};
            col_r  <= {CSW{1'b0}};
        end else begin
            d1_r   <= pc_dval_s;
            s1_r   <= pc_dval_s & pc_tag_s[0];
            win1_r <= win_s;
            if (pc_dval_s) begin
                x1_r  <= px_s;
                col_r <= cs_new_s;
            end
        end
    end

    // row stage: horizontal sliding sum of the last WH column sums
    always_comb begin
        s_base_s = s_r;
        s_sub_s  = {NOBIT{1'b0}};
        s_next_s = s_r;
        if (x1_r == {XW{1'b0}}) s_base_s = {NOBIT{1'b0}};
        else                    s_base_s = s_r;
        if (x1_r < XW'(WH))     s_sub_s = {NOBIT{1'b0}};
        else                    s_sub_s = NOBIT'(sr_r[WH-1]);
        if (d1_r) s_next_s = s_base_s + NOBIT'(col_r) - s_sub_s;
        else      s_next_s = s_r;
    end

    // row accumulator, column-sum shift register and registered outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s_r      <= {NOBIT{1'b0}};
            sr_r     <= {(WH*CSW){1'b0}};
            o_dval_r <= 1'b0;
            o_sof_r  <= 1'b0;
            o_data_r <= {NOBIT{1'b0}};
        end else begin
            s_r <= s_next_s;
            if (d1_r) begin
                sr_r <= {sr_r[WH-2:0], col_r};
            end
            o_dval_r <= d1_r & win1_r;
            o_sof_r  <= d1_r & s1_r & win1_r;
`ifdef CCA_BORDER_MASK_EN
            o_data_r <= (d1_r && win1_r) ? s_next_s : {NOBIT{1'b0}};
`else
            o_data_r <= s_next_s;
`endif
        end
    end

    assign bus.o_dval = o_dval_r;
    assign bus.o_sof  = o_sof_r;
    assign bus.o_data = o_data_r;

endmodule

// File: tb/tb_census_cost_aggregator.sv
// Scoreboard bench for census_cost_aggregator (WC=3, WH=3, M=8) against a window-sum reference model.
module tb_census_cost_aggregator;
    localparam int WC    = 3;
    localparam int WH    = 3;
    localparam int M     = 8;
    localparam int NCB   = 8;
    localparam int NOBIT = 7;
    localparam int LAT   = 5;
`ifdef CCA_BORDER_MASK_EN
    localparam int NOUT  = 36;
`else
    localparam int NOUT  = 64;
`endif

    typedef struct {
        logic [NOBIT-1:0] data;
        logic             sof;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    census_cost_aggregator_if #(.NCB(NCB), .NOBIT(NOBIT)) bus ();

    census_cost_aggregator #(.WC(WC), .WH(WH), .M(M)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    exp_t exp_q[$];
    int   cap_q[$];
    int   ref_q[$];
    int   checks = 0;
    int   errors = 0;

    int   img [0:63][0:M-1];
    int   mx = 0, my = 0;
    logic [NCB-1:0] fl [0:63];
    logic [NCB-1:0] fr [0:63];

    int   ncnt = 0, t_in = 0;
    bit   in_seen = 0, lat_done = 0;

    // reference: sum of pixel costs in the WH x WH window ending at (x,y), clipped at the frame origin
    function automatic int wsum(input int x, input int y);
        int s;
        s = 0;
        for (int r = y - WH + 1; r <= y; r++)
            for (int c = x - WH + 1; c <= x; c++)
                if (r >= 0 && c >= 0) s += img[r][c];
        return s;
    endfunction

    task automatic model_push(input logic [NCB-1:0] l, input logic [NCB-1:0] r, input logic sof);
        exp_t e;
        bit   ok;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = $countones(l ^ r);
        ok = 1'b1;
`ifdef CCA_BORDER_MASK_EN
        ok = (mx >= WH - 1) && (my >= WH - 1);
`endif
        if (ok) begin
            e.data = NOBIT'(wsum(mx, my));
            e.sof  = sof;
            exp_q.push_back(e);
        end
        mx++;
        if (mx == M) begin
            mx = 0;
            if (my < 63) my++;
        end
    endtask

    task automatic drive(input logic v, input logic [NCB-1:0] l, input logic [NCB-1:0] r, input logic sof);
        @(posedge clk);
        #1;
        bus.i_dval   = v;
        bus.i_data_l = l;
        bus.i_data_r = r;
        bus.i_sof    = sof;
        if (v && rstn) model_push(l, r, sof);
    endtask

    task automatic idle();
        drive(1'b0, NCB'($urandom), NCB'($urandom), 1'($urandom));
    endtask

    task automatic gen_frame(input int mode);
        for (int i = 0; i < 64; i++) begin
            fl[i] = NCB'($urandom);
            case (mode)
                1:       fr[i] = ~fl[i];
                2:       fr[i] = (i == 4 * M + 4) ? ~fl[i] : fl[i];
                3:       fr[i] = NCB'($urandom);
                default: fr[i] = fl[i];
            endcase
        end
    endtask

    task automatic send_frame(input int npix, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) idle();
            drive(1'b1, fl[i], fr[i], i == 0);
        end
        idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (LAT + 3) @(posedge clk);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int cap_at(input int i);
        return (i < cap_q.size()) ? cap_q[i] : -1;
    endfunction

    function automatic int count_val(input int v, input int from);
        int n;
        n = 0;
        for (int i = from; i < cap_q.size(); i++) if (cap_q[i] == v) n++;
        return n;
    endfunction

    // monitor: reset values, first-output latency, and scoreboard pops on o_dval
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                checks++;
                if (bus.o_dval !== 1'b0 || bus.o_sof !== 1'b0 || bus.o_data !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs: dval=%0b sof=%0b data=%0d, required all 0",
                             bus.o_dval, bus.o_sof, bus.o_data);
                end
            end else begin
                ncnt++;
                if (!in_seen && bus.i_dval === 1'b1) begin
                    in_seen = 1'b1;
                    t_in    = ncnt;
                end
                if (bus.o_dval === 1'b1) begin
                    if (in_seen && !lat_done) begin
                        lat_done = 1'b1;
                        check_int("first_latency", ncnt - t_in, LAT);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: data=%0d sof=%0b, required no output",
                                 bus.o_data, bus.o_sof);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.o_data !== e.data || bus.o_sof !== e.sof) begin
                            errors++;
                            $display("FAIL window_sum: got data=%0d sof=%0b, expected data=%0d sof=%0b",
                                     bus.o_data, bus.o_sof, e.data, e.sof);
                        end
                    end
                    cap_q.push_back(int'(bus.o_data));
                end
`ifdef CCA_BORDER_MASK_EN
                else begin
                    checks++;
                    if (bus.o_data !== '0 || bus.o_sof !== 1'b0) begin
                        errors++;
                        $display("FAIL masked_idle: data=%0d sof=%0b, required 0", bus.o_data, bus.o_sof);
                    end
                end
`endif
            end
        end
    end

    initial begin
        int base;
        bus.i_dval   = 1'b0;
        bus.i_sof    = 1'b0;
        bus.i_data_l = '0;
        bus.i_data_r = '0;
        rstn         = 1'b0;

        // reset held with random traffic on the inputs
        repeat (6) drive(1'b1, NCB'($urandom), NCB'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        bus.i_dval = 1'b0;
        rstn       = 1'b1;
        repeat (2) idle();

        // identical census vectors: zero cost everywhere
        cap_q.delete();
        gen_frame(0);
        send_frame(64, 1'b0);
        drain();
        check_int("equal_frame_count", cap_q.size(), NOUT);
        check_int("equal_frame_nonzero", NOUT - count_val(0, 0), 0);

        // complementary vectors: every pixel costs 8
        cap_q.delete();
        gen_frame(1);
        send_frame(64, 1'b0);
        drain();
        check_int("compl_count", cap_q.size(), NOUT);
`ifdef CCA_BORDER_MASK_EN
        check_int("compl_first", cap_at(0), 72);
        check_int("compl_all_72", count_val(72, 0), 36);
`else
        check_int("compl_px00", cap_at(0), 8);
        check_int("compl_px11", cap_at(9), 32);
        check_int("compl_px22", cap_at(18), 72);
`endif

        // a single cost-8 pixel at (4,4)
        cap_q.delete();
        gen_frame(2);
        send_frame(64, 1'b0);
        drain();
        check_int("single_hits_8", count_val(8, 0), 9);
        check_int("single_zeros", count_val(0, 0), NOUT - 9);

        // same random frame with and without input bubbles
        gen_frame(3);
        cap_q.delete();
        send_frame(64, 1'b0);
        drain();
        ref_q = cap_q;
        cap_q.delete();
        send_frame(64, 1'b1);
        drain();
        check_int("gap_count", cap_q.size(), ref_q.size());
        base = 0;
        for (int i = 0; i < cap_q.size() && i < ref_q.size(); i++) if (cap_q[i] != ref_q[i]) base++;
        check_int("gap_seq_diffs", base, 0);

        // frame restart by i_sof in the middle of a row
        cap_q.delete();
        gen_frame(1);
        send_frame(20, 1'b0);
        gen_frame(0);
        send_frame(64, 1'b0);
        drain();
        base = cap_q.size() - NOUT;
        if (base < 0) base = 0;
        check_int("restart_sof_zeros", count_val(0, base), NOUT);

        // frame restart by a reset pulse mid-frame
        gen_frame(1);
        send_frame(30, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        exp_q.delete();
        mx = 0;
        my = 0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        cap_q.delete();
        gen_frame(0);
        send_frame(64, 1'b1);
        drain();
        check_int("restart_rst_count", cap_q.size(), NOUT);
        check_int("restart_rst_zeros", count_val(0, 0), NOUT);

        // random frames with bubbles, checked only by the scoreboard
        for (int f = 0; f < 3; f++) begin
            gen_frame(3);
            send_frame(64, 1'b1);
        end
        drain();
        check_int("latency_checked", int'(lat_done), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
